// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared GPR constants and writeback requester indices
package gpr_pkg;
  localparam int RegAddrW = 5;
  localparam int NumRegs  = 32;
  localparam int REQ_ALU  = 0;
  localparam int REQ_LSU  = 1;
  localparam int REQ_MUL  = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; pointer moves past the winner on advance
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt;
  logic          found;

  // First pass covers indices at/after the pointer, second pass wraps around.
  always_comb begin
    gnt   = '0;
    nxt   = ptr;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && j >= int'(ptr) && req[j]) begin
        gnt[j] = 1'b1;
        nxt    = (j == N - 1) ? '0 : PW'(j + 1);
        found  = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && j < int'(ptr) && req[j]) begin
        gnt[j] = 1'b1;
        nxt    = (j == N - 1) ? '0 : PW'(j + 1);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= nxt;
    end
  end
endmodule

// File: rtl/gpr_wb_sched.sv
// rtl/gpr_wb_sched.sv - GPR writeback arbiter, write stage and pending-write scoreboard
module gpr_wb_sched
  import gpr_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int NumReq   = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  input  logic [RegAddrW-1:0]                issue_rs1n,
  input  logic [RegAddrW-1:0]                issue_rs2n,
  input  logic [RegAddrW-1:0]                issue_rdn,
  input  logic                               issue_wr,
  output logic                               issue_stall,
  input  logic [NumReq-1:0]                  req_valid,
  input  logic [NumReq-1:0][RegAddrW-1:0]    req_rdn,
  input  logic [NumReq-1:0][WordSize-1:0]    req_data,
  output logic [NumReq-1:0]                  req_ready,
  output logic                               gpr_wbe,
  output logic [RegAddrW-1:0]                gpr_rdn,
  output logic [WordSize-1:0]                gpr_rdd,
  output logic [NumRegs-1:0]                 busy
);
  logic [NumReq-1:0]   gnt;
  logic                hs;
  logic [RegAddrW-1:0] sel_rdn;
  logic [WordSize-1:0] sel_data;
  logic                issue_acc;
  logic [NumRegs-1:0]  set_mask;
  logic [NumRegs-1:0]  clr_mask;
  logic [NumRegs-1:0]  busy_nxt;

  rr_arbiter #(.N(NumReq)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (hs),
    .gnt     (gnt)
  );

  assign req_ready = rst ? '0 : gnt;
  assign hs        = |req_ready;

  always_comb begin
    sel_rdn  = '0;
    sel_data = '0;
    for (int j = 0; j < NumReq; j++) begin
      if (req_ready[j]) begin
        sel_rdn  = sel_rdn | req_rdn[j];
        sel_data = sel_data | req_data[j];
      end
    end
  end

  // Writes to x0 still complete the handshake but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_wbe <= 1'b0;
      gpr_rdn <= '0;
      gpr_rdd <= '0;
    end else begin
      gpr_wbe <= hs && (sel_rdn != '0);
      if (hs) begin
        gpr_rdn <= sel_rdn;
        gpr_rdd <= sel_data;
      end
    end
  end

  assign issue_stall = issue_valid &
                       (busy[issue_rs1n] | busy[issue_rs2n] | (issue_wr & busy[issue_rdn]));
  assign issue_acc   = issue_valid & ~issue_stall & issue_wr;

  // Set is applied after clear so a same-cycle issue to a retiring register wins.
  always_comb begin
    set_mask    = (issue_acc && issue_rdn != '0) ? (NumRegs'(1) << issue_rdn) : '0;
    clr_mask    = gpr_wbe ? (NumRegs'(1) << gpr_rdn) : '0;
    busy_nxt    = (busy & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_gpr_wb_sched.sv
// tb/tb_gpr_wb_sched.sv - self-checking bench for gpr_wb_sched
module tb_gpr_wb_sched;
  localparam int N = 3;
  localparam int W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [4:0]        issue_rs1n, issue_rs2n, issue_rdn;
  logic              issue_wr;
  logic              issue_stall;
  logic [N-1:0]      req_valid;
  logic [N-1:0][4:0] req_rdn;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]      req_ready;
  logic              gpr_wbe;
  logic [4:0]        gpr_rdn;
  logic [W-1:0]      gpr_rdd;
  logic [31:0]       busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mb;
  int          mptr;
  logic        mwbe;
  logic [4:0]  mrdn;
  logic [W-1:0] mrdd;

  typedef struct {
    logic [2:0] rv;
    logic       iv;
    logic [4:0] rs1, rs2, rd;
    logic       wr;
    logic [2:0] ready;
    logic       stall;
    logic       wbe;
  } vec_t;
  vec_t tbl[12];

  gpr_wb_sched #(.WordSize(W), .NumReq(N)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1n(issue_rs1n), .issue_rs2n(issue_rs2n),
    .issue_rdn(issue_rdn), .issue_wr(issue_wr), .issue_stall(issue_stall),
    .req_valid(req_valid), .req_rdn(req_rdn), .req_data(req_data), .req_ready(req_ready),
    .gpr_wbe(gpr_wbe), .gpr_rdn(gpr_rdn), .gpr_rdd(gpr_rdd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mb = '0; mptr = 0; mwbe = 1'b0; mrdn = '0; mrdd = '0;
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic clr_inputs();
    issue_valid = 0; issue_rs1n = 0; issue_rs2n = 0; issue_rdn = 0; issue_wr = 0;
    req_valid = 0;
    for (int i = 0; i < N; i++) begin
      req_rdn[i] = 5'(10 + i);
      req_data[i] = 32'hA000_0000 + 32'(i);
    end
  endtask

  task automatic set_issue(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic w);
    issue_valid = v; issue_rs1n = r1; issue_rs2n = r2; issue_rdn = rd; issue_wr = w;
  endtask

  // One clock against the reference model; called at the falling edge with inputs applied.
  task automatic cycle();
    int g;
    logic [2:0] er;
    logic es, acc;
    logic [31:0] nb;
    #1;
    g  = exp_grant();
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    es = issue_valid & (mb[issue_rs1n] | mb[issue_rs2n] | (issue_wr & mb[issue_rdn]));
    chk("m_req_ready", 64'(req_ready), 64'(er));
    chk("m_issue_stall", 64'(issue_stall), 64'(es));
    chk("m_busy", 64'(busy), 64'(mb));
    chk("m_gpr_wbe", 64'(gpr_wbe), 64'(mwbe));
    if (mwbe) begin
      chk("m_gpr_rdn", 64'(gpr_rdn), 64'(mrdn));
      chk("m_gpr_rdd", 64'(gpr_rdd), 64'(mrdd));
    end
    acc = issue_valid & ~es & issue_wr;
    @(posedge clk);
    nb = mb;
    if (mwbe) nb[mrdn] = 1'b0;
    if (acc && issue_rdn != 0) nb[issue_rdn] = 1'b1;
    mb = nb;
    if (g >= 0) begin
      mwbe = (req_rdn[g] != 0);
      mrdn = req_rdn[g];
      mrdd = req_data[g];
      mptr = (g + 1) % N;
    end else begin
      mwbe = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    req_valid = 3'b111;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_gpr_wbe", 64'(gpr_wbe), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clr_inputs();
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    model_reset();
    tbl[0]  = '{3'b111, 0, 0, 0, 0, 0, 3'b001, 0, 0};
    tbl[1]  = '{3'b111, 0, 0, 0, 0, 0, 3'b010, 0, 1};
    tbl[2]  = '{3'b111, 0, 0, 0, 0, 0, 3'b100, 0, 1};
    tbl[3]  = '{3'b111, 0, 0, 0, 0, 0, 3'b001, 0, 1};
    tbl[4]  = '{3'b111, 0, 0, 0, 0, 0, 3'b010, 0, 1};
    tbl[5]  = '{3'b111, 0, 0, 0, 0, 0, 3'b100, 0, 1};
    tbl[6]  = '{3'b000, 1, 0, 0, 5, 1, 3'b000, 0, 1};
    tbl[7]  = '{3'b000, 1, 5, 0, 0, 0, 3'b000, 1, 0};
    tbl[8]  = '{3'b110, 1, 5, 0, 0, 0, 3'b010, 1, 0};
    tbl[9]  = '{3'b000, 1, 0, 0, 9, 0, 3'b000, 0, 1};
    tbl[10] = '{3'b000, 1, 0, 5, 0, 0, 3'b000, 1, 0};
    tbl[11] = '{3'b101, 1, 0, 0, 11, 1, 3'b100, 0, 0};
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Table: round-robin fairness then basic hazards
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].rv;
      set_issue(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wr);
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].ready));
      chk($sformatf("tbl%0d_stall", i), 64'(issue_stall), 64'(tbl[i].stall));
      chk($sformatf("tbl%0d_wbe", i), 64'(gpr_wbe), 64'(tbl[i].wbe));
      cycle();
    end

    // RAW on x5 until the ALU writeback retires
    do_reset();
    set_issue(1, 0, 0, 5, 1);
    cycle();
    set_issue(1, 5, 0, 0, 0);
    #1; chk("raw_stall0", 64'(issue_stall), 64'd1);
    cycle();
    req_valid = 3'b001; req_rdn[0] = 5'd5; req_data[0] = 32'hDEADBEEF;
    #1; chk("raw_ready", 64'(req_ready), 64'd1);
    chk("raw_stall1", 64'(issue_stall), 64'd1);
    cycle();
    req_valid = 3'b000;
    #1; chk("raw_stall2", 64'(issue_stall), 64'd1);
    chk("raw_wbe", 64'(gpr_wbe), 64'd1);
    chk("raw_rdn", 64'(gpr_rdn), 64'd5);
    chk("raw_rdd", 64'(gpr_rdd), 64'hDEADBEEF);
    cycle();
    #1; chk("raw_stall3", 64'(issue_stall), 64'd0);
    cycle();

    // x0 writeback and issue
    do_reset();
    req_valid = 3'b001; req_rdn[0] = 5'd0; req_data[0] = 32'h1234;
    #1; chk("x0_ready", 64'(req_ready), 64'd1);
    cycle();
    req_valid = 3'b000;
    set_issue(1, 0, 0, 0, 1);
    #1; chk("x0_wbe", 64'(gpr_wbe), 64'd0);
    cycle();
    set_issue(0, 0, 0, 0, 0);
    #1; chk("x0_busy", 64'(busy), 64'd0);
    cycle();

    // Set/clear collision on x7
    do_reset();
    req_valid = 3'b001; req_rdn[0] = 5'd7; req_data[0] = 32'h7777;
    cycle();
    req_valid = 3'b000;
    set_issue(1, 0, 0, 7, 1);
    #1; chk("col_wbe", 64'(gpr_wbe), 64'd1);
    chk("col_stall", 64'(issue_stall), 64'd0);
    cycle();
    set_issue(0, 0, 0, 0, 0);
    #1; chk("col_busy7", 64'(busy[7]), 64'd1);
    cycle();

    // WAW on x9
    do_reset();
    set_issue(1, 0, 0, 9, 1);
    cycle();
    #1; chk("waw_stall_wr", 64'(issue_stall), 64'd1);
    cycle();
    issue_wr = 1'b0;
    #1; chk("waw_stall_nowr", 64'(issue_stall), 64'd0);
    cycle();

    // Reset with a writeback pending in the write stage
    do_reset();
    set_issue(1, 0, 0, 3, 1);
    req_valid = 3'b111; req_rdn[0] = 5'd4;
    cycle();
    set_issue(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1; chk("rstmid_wbe", 64'(gpr_wbe), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rstnext_wbe", 64'(gpr_wbe), 64'd0);
    chk("rstnext_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    model_reset();
    #1; chk("rst_first_grant", 64'(req_ready), 64'd1);
    cycle();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        req_rdn[i]  = 5'($urandom_range(0, 15));
        req_data[i] = $urandom;
      end
      set_issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
